// File: rtl/cpu_6502_pkg.sv
// Shared encodings for the 6502 interrupt/reset front end: interrupt types,
// vector addresses and the interrupt controller state encoding.
package cpu_6502_pkg;

    typedef enum logic [1:0] {
        INT_NONE  = 2'b00,
        INT_IRQ   = 2'b01,
        INT_NMI   = 2'b10,
        INT_RESET = 2'b11
    } int_type_e;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'b00,
        ST_RSTPEND = 2'b01,
        ST_IDLE    = 2'b10,
        ST_SERVICE = 2'b11
    } int_state_e;

    localparam logic [15:0] VEC_NMI   = 16'hFFFA;
    localparam logic [15:0] VEC_RESET = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ   = 16'hFFFE;

    // Vector low-byte address; "none" shares the IRQ/BRK vector.
    function automatic logic [15:0] vec_for(input int_type_e t);
        case (t)
            INT_NMI:   vec_for = VEC_NMI;
            INT_RESET: vec_for = VEC_RESET;
            default:   vec_for = VEC_IRQ;
        endcase
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for active-low pins; resets to the inactive (high) level.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/cpu_int_ctrl.sv
// 6502 interrupt/reset controller: synchronizes IRQ/NMI/res, sequences the
// reset hold and offers RESET/NMI/IRQ to the core sequencer at fetch boundaries.
module cpu_int_ctrl
    import cpu_6502_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYC = 2
) (
    input  logic        clk,
    input  logic        res,
    input  logic        IRQ,
    input  logic        NMI,
    input  logic        RDY,
    input  logic        sync,
    input  logic        i_flag,
    input  logic        ack,
    input  logic        done,
    output logic        core_rst,
    output logic        int_req,
    output logic [1:0]  int_type,
    output logic [15:0] vec_addr
);

    localparam int unsigned CNT_W = (RST_HOLD_CYC > 1) ? $clog2(RST_HOLD_CYC) : 1;

    logic             irq_s, nmi_s;
    logic             res_meta_q, res_meta_d;
    logic             res_sync_q, res_sync_d;
    logic             nmi_prev_q, nmi_prev_d;
    logic             nmi_pend_q, nmi_pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    int_state_e       state_q, state_d;
    logic             core_rst_q, core_rst_d;
    logic             int_req_q, int_req_d;
    int_type_e        int_type_q, int_type_d;
    logic             irq_act, nmi_fall, nmi_ack, hold_done;

    sync2 u_sync_irq (.clk(clk), .rst_n(res), .d(IRQ), .q(irq_s));
    sync2 u_sync_nmi (.clk(clk), .rst_n(res), .d(NMI), .q(nmi_s));

    always_comb begin
        res_meta_d = 1'b1;
        res_sync_d = res_meta_q;
        nmi_prev_d = nmi_s;
        cnt_d      = cnt_q;
        state_d    = state_q;
        core_rst_d = core_rst_q;
        int_req_d  = int_req_q;
        int_type_d = int_type_q;
        nmi_ack    = 1'b0;

        irq_act   = !irq_s && !i_flag;
        nmi_fall  = nmi_prev_q && !nmi_s;
        hold_done = (RST_HOLD_CYC == 0) || (cnt_q == CNT_W'(RST_HOLD_CYC - 1));

        // RDY low freezes sequencing; synchronizers and edge capture keep running.
        if (RDY) begin
            case (state_q)
                ST_HOLD: begin
                    if (res_sync_q) begin
                        if (hold_done) begin
                            state_d    = ST_RSTPEND;
                            core_rst_d = 1'b0;
                            int_req_d  = 1'b1;
                            int_type_d = INT_RESET;
                            cnt_d      = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_RSTPEND: begin
                    if (ack) begin
                        state_d   = ST_SERVICE;
                        int_req_d = 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (int_req_q) begin
                        if (ack) begin
                            state_d   = ST_SERVICE;
                            int_req_d = 1'b0;
                            nmi_ack   = (int_type_q == INT_NMI);
                        end else if (sync && (int_type_q == INT_IRQ) && !irq_act) begin
                            // IRQ went away before the core took it: withdraw the offer.
                            int_req_d  = 1'b0;
                            int_type_d = INT_NONE;
                        end
                    end else if (sync) begin
                        if (nmi_pend_q) begin
                            int_req_d  = 1'b1;
                            int_type_d = INT_NMI;
                        end else if (irq_act) begin
                            int_req_d  = 1'b1;
                            int_type_d = INT_IRQ;
                        end
                    end
                end
                ST_SERVICE: begin
                    if (done) begin
                        state_d    = ST_IDLE;
                        int_type_d = INT_NONE;
                    end
                end
                default: state_d = ST_HOLD;
            endcase
        end

        // A coincident new edge wins over the ack; edges seen during the hold are stale.
        nmi_pend_d = nmi_fall || (nmi_pend_q && !nmi_ack);
        if (state_q == ST_HOLD) begin
            nmi_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            res_meta_q <= 1'b0;
            res_sync_q <= 1'b0;
            nmi_prev_q <= 1'b1;
            nmi_pend_q <= 1'b0;
            cnt_q      <= '0;
            state_q    <= ST_HOLD;
            core_rst_q <= 1'b1;
            int_req_q  <= 1'b0;
            int_type_q <= INT_NONE;
        end else begin
            res_meta_q <= res_meta_d;
            res_sync_q <= res_sync_d;
            nmi_prev_q <= nmi_prev_d;
            nmi_pend_q <= nmi_pend_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            core_rst_q <= core_rst_d;
            int_req_q  <= int_req_d;
            int_type_q <= int_type_d;
        end
    end

    assign core_rst = core_rst_q;
    assign int_req  = int_req_q;
    assign int_type = int_type_q;
    assign vec_addr = vec_for(int_type_q);

endmodule

// File: tb/tb_cpu_int_ctrl.sv
// Directed bench for cpu_int_ctrl; observed word is {core_rst, int_req, int_type, vec_addr}.
module tb_cpu_int_ctrl;

    logic        clk;
    logic        res, IRQ, NMI, RDY, sync, i_flag, ack, done;
    logic        core_rst, int_req;
    logic [1:0]  int_type;
    logic [15:0] vec_addr;
    logic [19:0] obs;
    int          total, bad;

    cpu_int_ctrl #(.RST_HOLD_CYC(2)) dut (
        .clk(clk), .res(res), .IRQ(IRQ), .NMI(NMI), .RDY(RDY), .sync(sync),
        .i_flag(i_flag), .ack(ack), .done(done), .core_rst(core_rst),
        .int_req(int_req), .int_type(int_type), .vec_addr(vec_addr)
    );

    assign obs = {core_rst, int_req, int_type, vec_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_sync;
        sync = 1'b1; tick(1); sync = 1'b0;
    endtask

    task automatic pulse_ack;
        ack = 1'b1; tick(1); ack = 1'b0;
    endtask

    task automatic pulse_done;
        done = 1'b1; tick(1); done = 1'b0;
    endtask

    task automatic test_reset;
        tick(5);
        total++; if (obs !== 20'h8FFFE) begin bad++; $display("FAIL rst_state: got %h need %h", obs, 20'h8FFFE); end
        res = 1'b1;
        tick(1);
        total++; if (obs !== 20'h8FFFE) begin bad++; $display("FAIL hold_e1: got %h need %h", obs, 20'h8FFFE); end
        tick(1);
        total++; if (obs !== 20'h8FFFE) begin bad++; $display("FAIL hold_e2: got %h need %h", obs, 20'h8FFFE); end
        tick(1);
        total++; if (obs !== 20'h8FFFE) begin bad++; $display("FAIL hold_e3: got %h need %h", obs, 20'h8FFFE); end
        tick(1);
        total++; if (obs !== 20'h7FFFC) begin bad++; $display("FAIL rstpend_e4: got %h need %h", obs, 20'h7FFFC); end
        tick(3);
        total++; if (obs !== 20'h7FFFC) begin bad++; $display("FAIL rstpend_hold: got %h need %h", obs, 20'h7FFFC); end
        pulse_ack;
        total++; if (obs !== 20'h3FFFC) begin bad++; $display("FAIL rst_service: got %h need %h", obs, 20'h3FFFC); end
        tick(2);
        total++; if (obs !== 20'h3FFFC) begin bad++; $display("FAIL rst_service_hold: got %h need %h", obs, 20'h3FFFC); end
        pulse_done;
        total++; if (obs !== 20'h0FFFE) begin bad++; $display("FAIL rst_idle: got %h need %h", obs, 20'h0FFFE); end
        pulse_ack;
        pulse_done;
        pulse_sync;
        total++; if (obs !== 20'h0FFFE) begin bad++; $display("FAIL stray_ack_done: got %h need %h", obs, 20'h0FFFE); end
    endtask

    task automatic test_nmi;
        NMI = 1'b0; tick(3); NMI = 1'b1; tick(3);
        total++; if (obs !== 20'h0FFFE) begin bad++; $display("FAIL nmi_wait_sync: got %h need %h", obs, 20'h0FFFE); end
        pulse_sync;
        total++; if (obs !== 20'h6FFFA) begin bad++; $display("FAIL nmi_offer: got %h need %h", obs, 20'h6FFFA); end
        pulse_ack;
        total++; if (obs !== 20'h2FFFA) begin bad++; $display("FAIL nmi_service: got %h need %h", obs, 20'h2FFFA); end
        pulse_done;
        total++; if (obs !== 20'h0FFFE) begin bad++; $display("FAIL nmi_done: got %h need %h", obs, 20'h0FFFE); end
        pulse_sync;
        total++; if (obs !== 20'h0FFFE) begin bad++; $display("FAIL nmi_pend_clr: got %h need %h", obs, 20'h0FFFE); end
        NMI = 1'b0; tick(4);
        pulse_sync;
        total++; if (obs !== 20'h6FFFA) begin bad++; $display("FAIL nmi_long_offer: got %h need %h", obs, 20'h6FFFA); end
        pulse_ack;
        pulse_done;
        repeat (3) pulse_sync;
        total++; if (obs !== 20'h0FFFE) begin bad++; $display("FAIL nmi_no_retrig: got %h need %h", obs, 20'h0FFFE); end
        NMI = 1'b1; tick(4);
    endtask

    task automatic test_masked_irq;
        i_flag = 1'b1; IRQ = 1'b0; tick(3);
        for (int i = 0; i < 10; i++) begin
            pulse_sync;
            total++; if (obs !== 20'h0FFFE) begin bad++; $display("FAIL irq_masked[%0d]: got %h need %h", i, obs, 20'h0FFFE); end
        end
        i_flag = 1'b0;
        pulse_sync;
        total++; if (obs !== 20'h5FFFE) begin bad++; $display("FAIL irq_offer: got %h need %h", obs, 20'h5FFFE); end
        IRQ = 1'b1; tick(3);
        total++; if (obs !== 20'h5FFFE) begin bad++; $display("FAIL irq_type_held: got %h need %h", obs, 20'h5FFFE); end
        pulse_sync;
        total++; if (obs !== 20'h0FFFE) begin bad++; $display("FAIL irq_withdraw: got %h need %h", obs, 20'h0FFFE); end
        pulse_ack;
        tick(2);
        total++; if (obs !== 20'h0FFFE) begin bad++; $display("FAIL irq_no_phantom: got %h need %h", obs, 20'h0FFFE); end
    endtask

    task automatic test_simultaneous;
        IRQ = 1'b0; NMI = 1'b0; tick(3); NMI = 1'b1; tick(2);
        pulse_sync;
        total++; if (obs !== 20'h6FFFA) begin bad++; $display("FAIL simul_nmi_first: got %h need %h", obs, 20'h6FFFA); end
        pulse_ack;
        total++; if (obs !== 20'h2FFFA) begin bad++; $display("FAIL simul_nmi_svc: got %h need %h", obs, 20'h2FFFA); end
        pulse_done;
        total++; if (obs !== 20'h0FFFE) begin bad++; $display("FAIL simul_nmi_done: got %h need %h", obs, 20'h0FFFE); end
        pulse_sync;
        total++; if (obs !== 20'h5FFFE) begin bad++; $display("FAIL simul_irq_next: got %h need %h", obs, 20'h5FFFE); end
        pulse_ack;
        total++; if (obs !== 20'h1FFFE) begin bad++; $display("FAIL simul_irq_svc: got %h need %h", obs, 20'h1FFFE); end
        IRQ = 1'b1; tick(3);
        pulse_done;
        total++; if (obs !== 20'h0FFFE) begin bad++; $display("FAIL simul_irq_done: got %h need %h", obs, 20'h0FFFE); end
    endtask

    task automatic test_back_to_back;
        NMI = 1'b0; tick(2); NMI = 1'b1; tick(3);
        pulse_sync;
        total++; if (obs !== 20'h6FFFA) begin bad++; $display("FAIL nest_offer1: got %h need %h", obs, 20'h6FFFA); end
        pulse_ack;
        NMI = 1'b0; tick(2); NMI = 1'b1; tick(3);
        total++; if (obs !== 20'h2FFFA) begin bad++; $display("FAIL nest_svc_hold: got %h need %h", obs, 20'h2FFFA); end
        pulse_done;
        total++; if (obs !== 20'h0FFFE) begin bad++; $display("FAIL nest_done: got %h need %h", obs, 20'h0FFFE); end
        pulse_sync;
        total++; if (obs !== 20'h6FFFA) begin bad++; $display("FAIL nest_reoffer: got %h need %h", obs, 20'h6FFFA); end
        RDY = 1'b0; sync = 1'b1; ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            total++; if (obs !== 20'h6FFFA) begin bad++; $display("FAIL rdy_freeze[%0d]: got %h need %h", i, obs, 20'h6FFFA); end
        end
        RDY = 1'b1; sync = 1'b0; ack = 1'b0;
        pulse_ack;
        total++; if (obs !== 20'h2FFFA) begin bad++; $display("FAIL nest_ack2: got %h need %h", obs, 20'h2FFFA); end
        pulse_done;
        pulse_sync;
        total++; if (obs !== 20'h0FFFE) begin bad++; $display("FAIL nest_clear: got %h need %h", obs, 20'h0FFFE); end
    endtask

    task automatic test_abort;
        NMI = 1'b0; tick(2); NMI = 1'b1; tick(3);
        pulse_sync;
        pulse_ack;
        total++; if (obs !== 20'h2FFFA) begin bad++; $display("FAIL abort_pre: got %h need %h", obs, 20'h2FFFA); end
        NMI = 1'b0; tick(2); NMI = 1'b1; tick(3);
        #2 res = 1'b0;
        #1;
        total++; if (obs !== 20'h8FFFE) begin bad++; $display("FAIL abort_async: got %h need %h", obs, 20'h8FFFE); end
        tick(3);
        res = 1'b1;
        tick(3);
        total++; if (obs !== 20'h8FFFE) begin bad++; $display("FAIL abort_hold: got %h need %h", obs, 20'h8FFFE); end
        tick(1);
        total++; if (obs !== 20'h7FFFC) begin bad++; $display("FAIL abort_rstpend: got %h need %h", obs, 20'h7FFFC); end
        pulse_ack;
        pulse_done;
        repeat (2) pulse_sync;
        total++; if (obs !== 20'h0FFFE) begin bad++; $display("FAIL abort_nmi_dropped: got %h need %h", obs, 20'h0FFFE); end
    endtask

    initial begin
        total = 0; bad = 0;
        res = 1'b0; IRQ = 1'b1; NMI = 1'b1; RDY = 1'b1;
        sync = 1'b0; i_flag = 1'b0; ack = 1'b0; done = 1'b0;
        test_reset;
        test_nmi;
        test_masked_irq;
        test_simultaneous;
        test_back_to_back;
        test_abort;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
